// File: rtl/asteroid_pkg.sv
// asteroid_pkg: direction field encodings and start-position helpers shared
// by the asteroid motion engine (asteroid_field / asteroid_slot).
package asteroid_pkg;

    // x field (dir[3:2]) and y field (dir[1:0]) encodings
    localparam logic [1:0] DIR_X_POS = 2'b01;
    localparam logic [1:0] DIR_X_NEG = 2'b10;
    localparam logic [1:0] DIR_Y_NEG = 2'b01;
    localparam logic [1:0] DIR_Y_POS = 2'b10;

    // Screen midpoints derive from the edge coordinates by integer halving
    function automatic int mid_of(input int max_v);
        return max_v / 2;
    endfunction

    // Only the eight compass directions have a start position
    function automatic logic dir_valid(input logic [3:0] dir);
        case (dir)
            4'b0010, 4'b1010, 4'b1000, 4'b1001,
            4'b0001, 4'b0101, 4'b0100, 4'b0110: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Entry column: asteroids enter from the edge opposite their x motion
    function automatic int start_x_of(input logic [3:0] dir, input int x_max);
        case (dir)
            4'b0010, 4'b0001:          return mid_of(x_max);
            4'b1010, 4'b1000, 4'b1001: return x_max;
            default:                   return 0;
        endcase
    endfunction

    // Entry row: asteroids enter from the edge opposite their y motion
    function automatic int start_y_of(input logic [3:0] dir, input int y_max);
        case (dir)
            4'b1000, 4'b0100:          return mid_of(y_max);
            4'b1001, 4'b0001, 4'b0101: return y_max;
            default:                   return 0;
        endcase
    endfunction

endpackage

// File: rtl/asteroid_slot.sv
// asteroid_slot: one asteroid's position/direction/occupancy state and its
// per-tick step. Off-screen results despawn the slot, or wrap around the
// playfield when ASTEROID_WRAP_EN is defined.
module asteroid_slot import asteroid_pkg::*; #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119,
    parameter int STEP  = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [3:0]     load_dir,
    input  logic [X_W-1:0] load_x,
    input  logic [Y_W-1:0] load_y,
    input  logic           tick,
    input  logic           kill,
    output logic           active,
    output logic           despawn,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y
);

    // Two guard bits: one for the carry past the edge, one for the sign
    localparam int XC_W = X_W + 2;
    localparam int YC_W = Y_W + 2;
    localparam logic signed [XC_W-1:0] X_MAX_S  = XC_W'(X_MAX);
    localparam logic signed [YC_W-1:0] Y_MAX_S  = YC_W'(Y_MAX);
    localparam logic signed [XC_W-1:0] X_STEP_S = XC_W'(STEP);
    localparam logic signed [YC_W-1:0] Y_STEP_S = YC_W'(STEP);
`ifdef ASTEROID_WRAP_EN
    localparam logic signed [XC_W-1:0] X_SPAN_S = XC_W'(X_MAX + 1);
    localparam logic signed [YC_W-1:0] Y_SPAN_S = YC_W'(Y_MAX + 1);
`endif

    logic [3:0]              dir;
    logic signed [XC_W-1:0]  nxt_x;
    logic signed [YC_W-1:0]  nxt_y;
    logic                    off_screen;

    function automatic logic signed [XC_W-1:0] step_x(input logic signed [XC_W-1:0] v,
                                                      input logic [1:0] f);
        case (f)
            DIR_X_POS: return v + X_STEP_S;
            DIR_X_NEG: return v - X_STEP_S;
            default:   return v;
        endcase
    endfunction

    function automatic logic signed [YC_W-1:0] step_y(input logic signed [YC_W-1:0] v,
                                                      input logic [1:0] f);
        case (f)
            DIR_Y_POS: return v + Y_STEP_S;
            DIR_Y_NEG: return v - Y_STEP_S;
            default:   return v;
        endcase
    endfunction

`ifdef ASTEROID_WRAP_EN
    // STEP never exceeds the span, so a single correction suffices
    function automatic logic [X_W-1:0] wrap_x(input logic signed [XC_W-1:0] v);
        logic signed [XC_W-1:0] w;
        if (v[XC_W-1])        w = v + X_SPAN_S;
        else if (v > X_MAX_S) w = v - X_SPAN_S;
        else                  w = v;
        return w[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] wrap_y(input logic signed [YC_W-1:0] v);
        logic signed [YC_W-1:0] w;
        if (v[YC_W-1])        w = v + Y_SPAN_S;
        else if (v > Y_MAX_S) w = v - Y_SPAN_S;
        else                  w = v;
        return w[Y_W-1:0];
    endfunction
`endif

    // Candidate position for this tick and whether it leaves the playfield
    always_comb begin
        nxt_x      = step_x($signed({2'b00, pos_x}), dir[3:2]);
        nxt_y      = step_y($signed({2'b00, pos_y}), dir[1:0]);
        off_screen = nxt_x[XC_W-1] || (nxt_x > X_MAX_S) ||
                     nxt_y[YC_W-1] || (nxt_y > Y_MAX_S);
    end

    // Slot state: load beats kill beats move; kill suppresses move and despawn
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            despawn <= 1'b0;
            pos_x   <= '0;
            pos_y   <= '0;
        end else begin
            despawn <= 1'b0;
            if (load) begin
                active <= 1'b1;
                pos_x  <= load_x;
                pos_y  <= load_y;
                dir    <= load_dir;
            end else if (kill) begin
                active <= 1'b0;
            end else if (tick && active) begin
                if (off_screen) begin
`ifdef ASTEROID_WRAP_EN
                    pos_x <= wrap_x(nxt_x);
                    pos_y <= wrap_y(nxt_y);
`else
                    active  <= 1'b0;
                    despawn <= 1'b1;
`endif
                end else begin
                    pos_x <= nxt_x[X_W-1:0];
                    pos_y <= nxt_y[Y_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/asteroid_field.sv
// asteroid_field: NUM_AST-slot asteroid motion engine for the playfield.
// Holds the motion tick divider, the lowest-free-slot spawn encoder and the
// kill decode; per-slot motion lives in asteroid_slot.
// Optional feature macro: ASTEROID_WRAP_EN (wrap at screen edges, no despawn).
module asteroid_field import asteroid_pkg::*; #(
    parameter int NUM_AST  = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int STEP     = 3,
    parameter int TICK_DIV = 1250000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   spawn_valid,
    input  logic [3:0]             spawn_dir,
    output logic                   spawn_ready,
    output logic                   spawn_err,
    input  logic                   kill_valid,
    input  logic [3:0]             kill_idx,
    output logic [NUM_AST-1:0]     active,
    output logic [NUM_AST-1:0]     despawn,
    output logic [NUM_AST*X_W-1:0] pos_x,
    output logic [NUM_AST*Y_W-1:0] pos_y,
    output logic                   tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]   div_cnt;
    logic [NUM_AST-1:0] free_oh;
    logic               free_any;
    logic               accept;
    logic               dir_ok;
    logic [X_W-1:0]     start_x;
    logic [Y_W-1:0]     start_y;
    logic [NUM_AST-1:0] load_vec;
    logic [NUM_AST-1:0] kill_vec;

    // Motion divider: counts down, strobes tick while at zero, then reloads
    always_ff @(posedge clk) begin
        if (reset)                div_cnt <= CNT_LOAD;
        else if (div_cnt == '0)   div_cnt <= CNT_LOAD;
        else                      div_cnt <= div_cnt - CNT_W'(1);
    end

    assign tick = ~reset & (div_cnt == '0);

    // Lowest-index inactive slot; a slot being killed this cycle is still busy
    always_comb begin
        free_oh  = '0;
        free_any = 1'b0;
        for (int i = 0; i < NUM_AST; i++) begin
            if (!active[i] && !free_any) begin
                free_oh[i] = 1'b1;
                free_any   = 1'b1;
            end
        end
    end

    assign spawn_ready = ~reset & free_any;
    assign accept      = spawn_valid & spawn_ready;
    assign dir_ok      = dir_valid(spawn_dir);
    assign start_x     = X_W'(start_x_of(spawn_dir, X_MAX));
    assign start_y     = Y_W'(start_y_of(spawn_dir, Y_MAX));

    // Invalid directions still consume the handshake and flag the error
    always_ff @(posedge clk) begin
        if (reset) spawn_err <= 1'b0;
        else       spawn_err <= accept & ~dir_ok;
    end

    for (genvar g = 0; g < NUM_AST; g++) begin : g_slot
        assign load_vec[g] = accept & dir_ok & free_oh[g];
        assign kill_vec[g] = kill_valid & (kill_idx == 4'(g));

        asteroid_slot #(
            .X_W   (X_W),
            .Y_W   (Y_W),
            .X_MAX (X_MAX),
            .Y_MAX (Y_MAX),
            .STEP  (STEP)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load_vec[g]),
            .load_dir (spawn_dir),
            .load_x   (start_x),
            .load_y   (start_y),
            .tick     (tick),
            .kill     (kill_vec[g]),
            .active   (active[g]),
            .despawn  (despawn[g]),
            .pos_x    (pos_x[g*X_W +: X_W]),
            .pos_y    (pos_y[g*Y_W +: Y_W])
        );
    end

endmodule

// File: tb/tb_asteroid_field.sv
// tb_asteroid_field: scoreboard bench for asteroid_field (NUM_AST=2,
// TICK_DIV=4). A behavioural model predicts each cycle's outputs; the
// prediction is queued when stimulus is driven and popped after the edge.
module tb_asteroid_field;

    localparam int NUM_AST  = 2;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int X_MAX    = 159;
    localparam int Y_MAX    = 119;
    localparam int STEP     = 3;
    localparam int TICK_DIV = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   spawn_valid = 1'b0;
    logic [3:0]             spawn_dir = 4'd0;
    logic                   kill_valid = 1'b0;
    logic [3:0]             kill_idx = 4'd0;
    logic                   spawn_ready;
    logic                   spawn_err;
    logic [NUM_AST-1:0]     active;
    logic [NUM_AST-1:0]     despawn;
    logic [NUM_AST*X_W-1:0] pos_x;
    logic [NUM_AST*Y_W-1:0] pos_y;
    logic                   tick;

    always #5 clk = ~clk;

    asteroid_field #(
        .NUM_AST (NUM_AST), .X_W (X_W), .Y_W (Y_W), .X_MAX (X_MAX),
        .Y_MAX (Y_MAX), .STEP (STEP), .TICK_DIV (TICK_DIV)
    ) dut (
        .clk (clk), .reset (reset), .spawn_valid (spawn_valid),
        .spawn_dir (spawn_dir), .spawn_ready (spawn_ready),
        .spawn_err (spawn_err), .kill_valid (kill_valid),
        .kill_idx (kill_idx), .active (active), .despawn (despawn),
        .pos_x (pos_x), .pos_y (pos_y), .tick (tick)
    );

    typedef struct packed {
        logic [NUM_AST-1:0]     act;
        logic [NUM_AST-1:0]     desp;
        logic                   err;
        logic [NUM_AST*X_W-1:0] px;
        logic [NUM_AST*Y_W-1:0] py;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tick_cnt = 0;

    // Reference model state
    bit         m_act[NUM_AST];
    bit         m_desp[NUM_AST];
    int         m_x[NUM_AST];
    int         m_y[NUM_AST];
    logic [3:0] m_dir[NUM_AST];
    bit         m_err = 0;
    int         m_cnt = TICK_DIV - 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit start_of(input logic [3:0] d, output int sx, output int sy);
        sx = 0; sy = 0;
        case (d)
            4'b0010: begin sx = 79;  sy = 0;   end
            4'b1010: begin sx = 159; sy = 0;   end
            4'b1000: begin sx = 159; sy = 59;  end
            4'b1001: begin sx = 159; sy = 119; end
            4'b0001: begin sx = 79;  sy = 119; end
            4'b0101: begin sx = 0;   sy = 119; end
            4'b0100: begin sx = 0;   sy = 59;  end
            4'b0110: begin sx = 0;   sy = 0;   end
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic bit model_ready();
        bit r = 0;
        for (int i = 0; i < NUM_AST; i++) if (!m_act[i]) r = 1;
        return !reset && r;
    endfunction

    function automatic exp_t pack_exp();
        exp_t e;
        e = '0;
        for (int i = 0; i < NUM_AST; i++) begin
            e.act[i]              = m_act[i];
            e.desp[i]             = m_desp[i];
            e.px[i*X_W +: X_W]    = X_W'(m_x[i]);
            e.py[i*Y_W +: Y_W]    = Y_W'(m_y[i]);
        end
        e.err = m_err;
        return e;
    endfunction

    task automatic model_step(input logic sv, input logic [3:0] sd, input logic kv, input logic [3:0] ki);
        bit n_act[NUM_AST];
        int free_i, sx, sy, nx, ny;
        bit acc, is_tick;
        if (reset) begin
            for (int i = 0; i < NUM_AST; i++) begin
                m_act[i] = 0; m_desp[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_err = 0;
            m_cnt = TICK_DIV - 1;
            return;
        end
        free_i = -1;
        for (int i = 0; i < NUM_AST; i++) if (!m_act[i] && free_i < 0) free_i = i;
        acc     = sv && (free_i >= 0);
        is_tick = (m_cnt == 0);
        if (is_tick) tick_cnt++;
        for (int i = 0; i < NUM_AST; i++) begin
            n_act[i]  = m_act[i];
            m_desp[i] = 0;
            if (kv && ki == 4'(i)) begin
                n_act[i] = 0;
            end else if (m_act[i] && is_tick) begin
                nx = m_x[i] + ((m_dir[i][3:2] == 2'b01) ? STEP : (m_dir[i][3:2] == 2'b10) ? -STEP : 0);
                ny = m_y[i] + ((m_dir[i][1:0] == 2'b10) ? STEP : (m_dir[i][1:0] == 2'b01) ? -STEP : 0);
`ifdef ASTEROID_WRAP_EN
                if (nx < 0) nx += X_MAX + 1;
                if (nx > X_MAX) nx -= X_MAX + 1;
                if (ny < 0) ny += Y_MAX + 1;
                if (ny > Y_MAX) ny -= Y_MAX + 1;
                m_x[i] = nx; m_y[i] = ny;
`else
                if (nx < 0 || nx > X_MAX || ny < 0 || ny > Y_MAX) begin
                    n_act[i] = 0; m_desp[i] = 1;
                end else begin
                    m_x[i] = nx; m_y[i] = ny;
                end
`endif
            end
        end
        m_err = 0;
        if (acc) begin
            if (start_of(sd, sx, sy)) begin
                n_act[free_i] = 1; m_x[free_i] = sx; m_y[free_i] = sy; m_dir[free_i] = sd;
            end else begin
                m_err = 1;
            end
        end
        for (int i = 0; i < NUM_AST; i++) m_act[i] = n_act[i];
        m_cnt = is_tick ? TICK_DIV - 1 : m_cnt - 1;
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'(1), 64'(0));
            return;
        end
        e = sb_q.pop_front();
        check("active",    64'(active),    64'(e.act));
        check("despawn",   64'(despawn),   64'(e.desp));
        check("spawn_err", 64'(spawn_err), 64'(e.err));
        check("pos_x",     64'(pos_x),     64'(e.px));
        check("pos_y",     64'(pos_y),     64'(e.py));
    endtask

    // One clock: drive at negedge, check combinational outputs, predict, compare after edge
    task automatic cycle(input logic sv, input logic [3:0] sd, input logic kv, input logic [3:0] ki);
        spawn_valid = sv; spawn_dir = sd; kill_valid = kv; kill_idx = ki;
        #1;
        check("spawn_ready", 64'(spawn_ready), 64'(model_ready()));
        check("tick",        64'(tick),        64'(!reset && m_cnt == 0));
        model_step(sv, sd, kv, ki);
        sb_q.push_back(pack_exp());
        @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
        spawn_valid = 1'b0; kill_valid = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(); idle();
        reset = 1'b0;
    endtask

    function automatic logic [X_W-1:0] slot_x(input int i);
        return pos_x[i*X_W +: X_W];
    endfunction

    function automatic logic [Y_W-1:0] slot_y(input int i);
        return pos_y[i*Y_W +: Y_W];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, guard, sx0, sy0;
        @(negedge clk);
        idle(); idle();

        // Reset release: tick on the 4th cycle, then every 4
        reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            #1;
            check("tick_seq", 64'(tick), 64'(i % 4 == 0));
            idle();
        end
        check("idle_active", 64'(active), 64'(0));
        check("idle_pos_x", 64'(pos_x), 64'(0));

        // Spawn from the right edge, moving -x
        do_reset();
        cycle(1'b1, 4'b1000, 1'b0, 4'd0);
        check("sp1000_act", 64'(active), 64'(2'b01));
        check("sp1000_x", 64'(slot_x(0)), 64'(159));
        check("sp1000_y", 64'(slot_y(0)), 64'(59));
        base = tick_cnt; guard = 0;
        while (tick_cnt == base && guard < 10) begin idle(); guard++; end
        check("tick1_bound", 64'(guard < 10), 64'(1));
        check("tick1_x", 64'(slot_x(0)), 64'(156));
        check("tick1_y", 64'(slot_y(0)), 64'(59));

        // Cross to the right edge from x=0
        do_reset();
        cycle(1'b1, 4'b0100, 1'b0, 4'd0);
        base = tick_cnt; guard = 0;
        while (tick_cnt - base < 53 && guard < 400) begin idle(); guard++; end
        check("t53_bound", 64'(guard < 400), 64'(1));
        check("t53_x", 64'(slot_x(0)), 64'(159));
        check("t53_act", 64'(active[0]), 64'(1));
        guard = 0;
        while (tick_cnt - base < 54 && guard < 10) begin idle(); guard++; end
`ifdef ASTEROID_WRAP_EN
        check("t54_x", 64'(slot_x(0)), 64'(2));
        check("t54_act", 64'(active[0]), 64'(1));
        check("t54_desp", 64'(despawn[0]), 64'(0));
`else
        check("t54_x", 64'(slot_x(0)), 64'(159));
        check("t54_act", 64'(active[0]), 64'(0));
        check("t54_desp", 64'(despawn[0]), 64'(1));
`endif
        idle();
        check("t55_desp", 64'(despawn[0]), 64'(0));

        // Fill both slots, refuse a third, free one by kill
        do_reset();
        cycle(1'b1, 4'b1000, 1'b0, 4'd0);
        cycle(1'b1, 4'b0010, 1'b0, 4'd0);
        check("full_ready", 64'(spawn_ready), 64'(0));
        cycle(1'b1, 4'b0100, 1'b0, 4'd0);
        check("full_act", 64'(active), 64'(2'b11));
        cycle(1'b0, 4'd0, 1'b1, 4'd5);
        check("kill_oob", 64'(active), 64'(2'b11));
        cycle(1'b0, 4'd0, 1'b1, 4'd0);
        check("kill0_act", 64'(active), 64'(2'b10));
        check("kill0_ready", 64'(spawn_ready), 64'(1));
        cycle(1'b1, 4'b0100, 1'b0, 4'd0);
        check("reload_act", 64'(active), 64'(2'b11));
        check("reload_x", 64'(slot_x(0)), 64'(0));
        check("reload_y", 64'(slot_y(0)), 64'(59));
        cycle(1'b1, 4'b0110, 1'b1, 4'd1);
        check("kill_spawn_act", 64'(active), 64'(2'b01));
        cycle(1'b1, 4'b0110, 1'b0, 4'd0);
        check("after_ks_act", 64'(active), 64'(2'b11));
        check("after_ks_x", 64'(slot_x(1)), 64'(0));

        // Invalid directions
        cycle(1'b0, 4'd0, 1'b1, 4'd1);
        cycle(1'b1, 4'b0011, 1'b0, 4'd0);
        check("err0011", 64'(spawn_err), 64'(1));
        check("err0011_act", 64'(active), 64'(2'b01));
        idle();
        check("err_clear", 64'(spawn_err), 64'(0));
        cycle(1'b1, 4'b0000, 1'b0, 4'd0);
        check("err0000", 64'(spawn_err), 64'(1));

        // Spawn and kill both landing on a tick cycle
        do_reset();
        cycle(1'b1, 4'b1000, 1'b0, 4'd0);
        guard = 0;
        while (m_cnt != 0 && guard < 10) begin idle(); guard++; end
        check("align_bound", 64'(guard < 10), 64'(1));
        sx0 = m_x[0]; sy0 = m_y[0];
        cycle(1'b1, 4'b0100, 1'b1, 4'd0);
        check("tk_act", 64'(active), 64'(2'b10));
        check("tk_desp", 64'(despawn), 64'(0));
        check("tk_new_x", 64'(slot_x(1)), 64'(0));
        check("tk_new_y", 64'(slot_y(1)), 64'(59));
        check("tk_kill_x", 64'(slot_x(0)), 64'(sx0));
        check("tk_kill_y", 64'(slot_y(0)), 64'(sy0));

        // Reset mid-operation
        reset = 1'b1;
        idle();
        check("mid_rst_act", 64'(active), 64'(0));
        check("mid_rst_x", 64'(pos_x), 64'(0));
        reset = 1'b0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
